// File: rtl/icache_nway.sv
// N-way set-associative instruction cache with flop storage, round-robin replacement,
// one-cycle hit path and a line refill engine that fills one word per memory beat.
module icache_nway #(
    parameter int ADDR_WIDTH  = 16,
    parameter int WORD_WIDTH  = 20,
    parameter int NUM_WAYS    = 4,
    parameter int SET_BITS    = 4,
    parameter int OFFSET_BITS = 4
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic                  i_valid,
    input  logic                  i_halt,
    input  logic                  i_flush,
    output logic                  o_ready,
    output logic [WORD_WIDTH-1:0] o_data,
    output logic                  o_valid,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic                  o_mem_req_valid,
    input  logic                  i_mem_req_ready,
    input  logic [WORD_WIDTH-1:0] i_mem_data,
    input  logic                  i_mem_data_valid
);

    localparam int TAG_BITS   = ADDR_WIDTH - SET_BITS - OFFSET_BITS;
    localparam int NUM_SETS   = 1 << SET_BITS;
    localparam int LINE_WORDS = 1 << OFFSET_BITS;
    localparam int WAY_BITS   = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MISS_REQ,
        S_REFILL,
        S_RESPOND,
        S_FLUSH
    } state_t;

    state_t                               state_q, state_d;
    logic [ADDR_WIDTH-1:0]                addr_q, addr_d;
    logic [WAY_BITS-1:0]                  victim_q, victim_d;
    logic                                 victim_inv_q, victim_inv_d;
    logic [OFFSET_BITS-1:0]               cnt_q, cnt_d;
    logic [SET_BITS-1:0]                  fset_q, fset_d;
    logic [WORD_WIDTH-1:0]                resp_word_q, resp_word_d;
    logic [WORD_WIDTH-1:0]                o_data_q, o_data_d;
    logic                                 o_valid_q, o_valid_d;
    logic [NUM_SETS-1:0][NUM_WAYS-1:0]    valid_q, valid_d;
    logic [NUM_SETS-1:0][WAY_BITS-1:0]    rr_q, rr_d;

    logic [TAG_BITS-1:0]   tag_q  [NUM_SETS][NUM_WAYS];
    logic [WORD_WIDTH-1:0] data_q [NUM_SETS][NUM_WAYS][LINE_WORDS];

    logic [TAG_BITS-1:0]    req_tag, lat_tag;
    logic [SET_BITS-1:0]    req_set, lat_set;
    logic [OFFSET_BITS-1:0] req_off, lat_off;

    logic                  hit, inv_found, accept, data_we, tag_we;
    logic [WAY_BITS-1:0]   hit_way, inv_way;
    logic [WORD_WIDTH-1:0] hit_word;

    assign req_tag = i_addr[ADDR_WIDTH-1 -: TAG_BITS];
    assign req_set = i_addr[OFFSET_BITS +: SET_BITS];
    assign req_off = i_addr[OFFSET_BITS-1:0];
    assign lat_tag = addr_q[ADDR_WIDTH-1 -: TAG_BITS];
    assign lat_set = addr_q[OFFSET_BITS +: SET_BITS];
    assign lat_off = addr_q[OFFSET_BITS-1:0];

    assign o_ready         = (state_q == S_IDLE) & ~i_halt & ~i_flush;
    assign accept          = i_valid & o_ready;
    assign o_data          = o_data_q;
    assign o_valid         = o_valid_q;
    assign o_mem_req_valid = (state_q == S_MISS_REQ);
    assign o_mem_addr      = {addr_q[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};

    // Tag compare and victim search on the incoming address; the descending scan
    // leaves the lowest-index invalid way as the winner.
    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (valid_q[req_set][w] && (tag_q[req_set][w] == req_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_BITS'(w);
            end
        end
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (!valid_q[req_set][w]) begin
                inv_found = 1'b1;
                inv_way   = WAY_BITS'(w);
            end
        end
        hit_word = data_q[req_set][hit_way][req_off];
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        victim_d     = victim_q;
        victim_inv_d = victim_inv_q;
        cnt_d        = cnt_q;
        fset_d       = fset_q;
        resp_word_d  = resp_word_q;
        o_data_d     = o_data_q;
        o_valid_d    = o_valid_q;
        valid_d      = valid_q;
        rr_d         = rr_q;
        data_we      = 1'b0;
        tag_we       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!i_halt) begin
                    o_valid_d = 1'b0;
                end
                if (i_flush) begin
                    state_d = S_FLUSH;
                    fset_d  = '0;
                end else if (accept) begin
                    if (hit) begin
                        o_data_d  = hit_word;
                        o_valid_d = 1'b1;
                    end else begin
                        addr_d       = i_addr;
                        victim_d     = inv_found ? inv_way : rr_q[req_set];
                        victim_inv_d = inv_found;
                        cnt_d        = '0;
                        state_d      = S_MISS_REQ;
                    end
                end
            end
            S_MISS_REQ: begin
                if (i_mem_req_ready) begin
                    state_d = S_REFILL;
                end
            end
            S_REFILL: begin
                if (i_mem_data_valid) begin
                    data_we = 1'b1;
                    cnt_d   = cnt_q + OFFSET_BITS'(1);
                    if (cnt_q == lat_off) begin
                        resp_word_d = i_mem_data;
                    end
                    if (&cnt_q) begin
                        tag_we                    = 1'b1;
                        valid_d[lat_set][victim_q] = 1'b1;
                        if (!victim_inv_q && (NUM_WAYS > 1)) begin
                            rr_d[lat_set] = rr_q[lat_set] + WAY_BITS'(1);
                        end
                        state_d = S_RESPOND;
                        // A halt on the final beat defers the load to RESPOND.
                        if (!i_halt) begin
                            o_data_d  = (cnt_q == lat_off) ? i_mem_data : resp_word_q;
                            o_valid_d = 1'b1;
                        end
                    end
                end
            end
            S_RESPOND: begin
                if (!i_halt) begin
                    if (o_valid_q) begin
                        o_valid_d = 1'b0;
                        state_d   = S_IDLE;
                    end else begin
                        o_data_d  = resp_word_q;
                        o_valid_d = 1'b1;
                    end
                end
            end
            S_FLUSH: begin
                valid_d[fset_q] = '0;
                rr_d[fset_q]    = '0;
                fset_d          = fset_q + SET_BITS'(1);
                if (&fset_q) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            victim_q     <= '0;
            victim_inv_q <= 1'b0;
            cnt_q        <= '0;
            fset_q       <= '0;
            resp_word_q  <= '0;
            o_data_q     <= '0;
            o_valid_q    <= 1'b0;
            valid_q      <= '0;
            rr_q         <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            victim_q     <= victim_d;
            victim_inv_q <= victim_inv_d;
            cnt_q        <= cnt_d;
            fset_q       <= fset_d;
            resp_word_q  <= resp_word_d;
            o_data_q     <= o_data_d;
            o_valid_q    <= o_valid_d;
            valid_q      <= valid_d;
            rr_q         <= rr_d;
        end
    end

    // Tag and data arrays are qualified by the valid bits, so they carry no reset.
    always_ff @(posedge clk) begin
        if (data_we) begin
            data_q[lat_set][victim_q][cnt_q] <= i_mem_data;
        end
        if (tag_we) begin
            tag_q[lat_set][victim_q] <= lat_tag;
        end
    end

endmodule

// File: tb/tb_icache_nway.sv
// Randomized self-checking bench for icache_nway against a set/way/round-robin model
// of the cache contents and a deterministic backing-memory pattern.
module tb_icache_nway;

    localparam int AW    = 16;
    localparam int WW    = 20;
    localparam int NW    = 4;
    localparam int NSETS = 16;
    localparam int LW    = 16;

    logic          clk = 1'b0;
    logic          arst;
    logic [AW-1:0] i_addr;
    logic          i_valid, i_halt, i_flush;
    logic          o_ready;
    logic [WW-1:0] o_data;
    logic          o_valid;
    logic [AW-1:0] o_mem_addr;
    logic          o_mem_req_valid;
    logic          i_mem_req_ready;
    logic [WW-1:0] i_mem_data;
    logic          i_mem_data_valid;

    always #5 clk = ~clk;

    icache_nway #(
        .ADDR_WIDTH (AW),
        .WORD_WIDTH (WW),
        .NUM_WAYS   (NW),
        .SET_BITS   (4),
        .OFFSET_BITS(4)
    ) dut (
        .clk             (clk),
        .arst            (arst),
        .i_addr          (i_addr),
        .i_valid         (i_valid),
        .i_halt          (i_halt),
        .i_flush         (i_flush),
        .o_ready         (o_ready),
        .o_data          (o_data),
        .o_valid         (o_valid),
        .o_mem_addr      (o_mem_addr),
        .o_mem_req_valid (o_mem_req_valid),
        .i_mem_req_ready (i_mem_req_ready),
        .i_mem_data      (i_mem_data),
        .i_mem_data_valid(i_mem_data_valid)
    );

    int n_tests = 0;
    int n_fail  = 0;

    bit m_valid [NSETS][NW];
    int m_tag   [NSETS][NW];
    int m_rr    [NSETS];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Backing memory: line 0x123 holds 0x100+offset, other lines differ in the upper bits.
    function automatic logic [WW-1:0] mem_word(input logic [AW-1:0] a);
        logic [11:0] ln;
        ln = a[15:4] ^ 12'h123;
        return {ln, 8'h00} + {16'h0010, a[3:0]};
    endfunction

    function automatic bit model_hit(input logic [AW-1:0] a);
        int s;
        int t;
        s = int'(a[7:4]);
        t = int'(a[15:8]);
        for (int w = 0; w < NW; w++) begin
            if (m_valid[s][w] && m_tag[s][w] == t) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic void model_fill(input logic [AW-1:0] a);
        int s;
        int v;
        s = int'(a[7:4]);
        v = -1;
        for (int w = 0; w < NW; w++) begin
            if (!m_valid[s][w] && v < 0) v = w;
        end
        if (v < 0) begin
            v       = m_rr[s];
            m_rr[s] = (m_rr[s] + 1) % NW;
        end
        m_valid[s][v] = 1'b1;
        m_tag[s][v]   = int'(a[15:8]);
    endfunction

    function automatic void model_clear();
        for (int s = 0; s < NSETS; s++) begin
            m_rr[s] = 0;
            for (int w = 0; w < NW; w++) begin
                m_valid[s][w] = 1'b0;
                m_tag[s][w]   = 0;
            end
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [AW-1:0] a, input int req_wait, input int halt_resp,
                         output bit obs_miss);
        bit            exp_hit;
        logic [AW-1:0] line;
        int            gap;
        exp_hit = model_hit(a);
        line    = {a[AW-1:4], 4'h0};
        i_addr  = a;
        i_valid = 1'b1;
        #1;
        check("ready_idle", 32'(o_ready), 32'd1);
        step();
        i_valid  = 1'b0;
        i_addr   = AW'($urandom);
        obs_miss = o_mem_req_valid;
        check("hit_vs_miss", 32'(o_mem_req_valid), 32'(!exp_hit));
        if (exp_hit) begin
            check("hit_valid", 32'(o_valid), 32'd1);
            check("hit_data", 32'(o_data), 32'(mem_word(a)));
            return;
        end
        check("miss_no_valid", 32'(o_valid), 32'd0);
        check("miss_addr", 32'(o_mem_addr), 32'(line));
        for (int k = 0; k < req_wait; k++) begin
            i_mem_data_valid = 1'b1;
            i_mem_data       = 20'hBADBA;
            step();
            check("req_hold_valid", 32'(o_mem_req_valid), 32'd1);
            check("req_hold_addr", 32'(o_mem_addr), 32'(line));
            check("req_hold_ready", 32'(o_ready), 32'd0);
        end
        i_mem_data_valid = 1'b0;
        i_mem_req_ready  = 1'b1;
        step();
        i_mem_req_ready = 1'b0;
        check("req_drop", 32'(o_mem_req_valid), 32'd0);
        for (int b = 0; b < LW; b++) begin
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                i_halt     = 1'($urandom_range(0, 1));
                i_mem_data = 20'h5EED5;
                step();
            end
            i_halt           = (b == LW - 1) ? 1'b0 : 1'($urandom_range(0, 1));
            i_mem_data_valid = 1'b1;
            i_mem_data       = mem_word(line | AW'(b));
            step();
            i_mem_data_valid = 1'b0;
        end
        i_halt = 1'b0;
        check("resp_valid", 32'(o_valid), 32'd1);
        check("resp_data", 32'(o_data), 32'(mem_word(a)));
        model_fill(a);
        if (halt_resp > 0) begin
            i_halt = 1'b1;
            for (int h = 0; h < halt_resp; h++) begin
                step();
                check("halt_hold_valid", 32'(o_valid), 32'd1);
                check("halt_hold_data", 32'(o_data), 32'(mem_word(a)));
            end
            i_halt = 1'b0;
        end
        step();
        check("resp_done", 32'(o_valid), 32'd0);
        check("resp_ready", 32'(o_ready), 32'd1);
    endtask

    task automatic do_flush(input logic [AW-1:0] probe);
        i_flush = 1'b1;
        i_valid = 1'b1;
        i_addr  = probe;
        #1;
        check("flush_ready_low", 32'(o_ready), 32'd0);
        step();
        i_flush = 1'b0;
        for (int c = 0; c < NSETS; c++) begin
            check("flush_busy", 32'(o_ready), 32'd0);
            check("flush_no_accept", 32'(o_valid), 32'd0);
            step();
        end
        check("flush_done_ready", 32'(o_ready), 32'd1);
        i_valid = 1'b0;
        model_clear();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit            m;
        logic [AW-1:0] a;
        int            r;
        arst             = 1'b1;
        i_addr           = '0;
        i_valid          = 1'b0;
        i_halt           = 1'b0;
        i_flush          = 1'b0;
        i_mem_req_ready  = 1'b0;
        i_mem_data       = '0;
        i_mem_data_valid = 1'b0;
        model_clear();
        #12;
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_req", 32'(o_mem_req_valid), 32'd0);
        check("rst_mem_addr", 32'(o_mem_addr), 32'd0);
        check("rst_data", 32'(o_data), 32'd0);
        check("rst_ready", 32'(o_ready), 32'd1);
        step();
        arst = 1'b0;
        step();

        // Cold miss, then hits in the same line back to back.
        fetch(16'h1234, 2, 0, m);
        check("cold_miss", 32'(m), 32'd1);
        fetch(16'h1237, 0, 0, m);
        check("warm_hit", 32'(m), 32'd0);
        check("warm_data", 32'(o_data), 32'h00107);
        fetch(16'h1230, 0, 0, m);
        fetch(16'h123F, 0, 0, m);
        check("b2b_data", 32'(o_data), 32'h0010F);

        // Halt in IDLE freezes the output and blocks acceptance.
        i_halt  = 1'b1;
        i_valid = 1'b1;
        i_addr  = 16'h1231;
        #1;
        check("halt_idle_ready", 32'(o_ready), 32'd0);
        for (int k = 0; k < 2; k++) begin
            step();
            check("halt_idle_valid", 32'(o_valid), 32'd1);
            check("halt_idle_data", 32'(o_data), 32'h0010F);
        end
        i_halt  = 1'b0;
        i_valid = 1'b0;
        step();
        check("idle_drop", 32'(o_valid), 32'd0);

        do_flush(16'h1237);
        fetch(16'h1234, 0, 0, m);
        check("post_flush_miss", 32'(m), 32'd1);

        fetch(16'h2340, 10, 0, m);
        fetch(16'h3456, 0, 3, m);

        // Replacement in set 3 from a clean cache.
        do_flush(16'h0000);
        for (int t = 1; t <= 5; t++) begin
            fetch(AW'((t << 8) | 16'h0035), 0, 0, m);
            check("repl_fill_miss", 32'(m), 32'd1);
        end
        fetch(16'h0239, 0, 0, m);
        check("repl_tag2_hit", 32'(m), 32'd0);
        fetch(16'h013A, 0, 0, m);
        check("repl_tag1_miss", 32'(m), 32'd1);

        // Reset in the middle of a refill.
        a       = 16'h4A52;
        i_addr  = a;
        i_valid = 1'b1;
        step();
        i_valid = 1'b0;
        check("abort_req", 32'(o_mem_req_valid), 32'd1);
        i_mem_req_ready = 1'b1;
        step();
        i_mem_req_ready = 1'b0;
        for (int b = 0; b < 8; b++) begin
            i_mem_data_valid = 1'b1;
            i_mem_data       = mem_word({a[15:4], 4'h0} | AW'(b));
            step();
        end
        arst = 1'b1;
        #2;
        check("abort_rst_valid", 32'(o_valid), 32'd0);
        check("abort_rst_req", 32'(o_mem_req_valid), 32'd0);
        check("abort_rst_addr", 32'(o_mem_addr), 32'd0);
        check("abort_rst_data", 32'(o_data), 32'd0);
        i_mem_data_valid = 1'b0;
        step();
        arst = 1'b0;
        model_clear();
        step();
        fetch(a, 0, 0, m);
        check("abort_refetch_miss", 32'(m), 32'd1);

        // Randomized traffic over a few sets with more tags than ways.
        repeat (250) begin
            r = $urandom_range(0, 19);
            if (r == 0) begin
                do_flush(AW'($urandom));
            end else if (r < 3) begin
                step();
                check("rand_idle_drop", 32'(o_valid), 32'd0);
            end else begin
                a = {8'($urandom_range(0, 5)), 4'($urandom_range(0, 2)), 4'($urandom_range(0, 15))};
                fetch(a, $urandom_range(0, 3),
                      ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 0, m);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/icache_nway.md
ICACHE_NWAY -- requirements
Module: icache_nway

Interface
REQ-001 Parameter ADDR_WIDTH, default 16: request address width in words.
REQ-002 Parameter WORD_WIDTH, default 20: instruction word width.
REQ-003 Parameter NUM_WAYS, default 4: associativity; legal values are 1, 2, 4 and 8.
REQ-004 Parameter SET_BITS, default 4: number of sets is 2^SET_BITS.
REQ-005 Parameter OFFSET_BITS, default 4: words per line is 2^OFFSET_BITS.
REQ-006 Tag width TAG_BITS is ADDR_WIDTH-SET_BITS-OFFSET_BITS, which SHALL be at least 1.
REQ-007 Port clk, in, 1: single clock; all logic is rising-edge.
REQ-008 Port arst, in, 1: asynchronous, active-high reset.
REQ-009 Port i_addr, in, ADDR_WIDTH: fetch address, split as {tag, set, offset} from MSB to LSB.
REQ-010 Port i_valid, in, 1: fetch request valid.
REQ-011 Port i_halt, in, 1: stall; blocks acceptance and freezes the output register.
REQ-012 Port i_flush, in, 1: invalidate-all request, sampled only in IDLE.
REQ-013 Port o_ready, out, 1: high only when a request can be accepted.
REQ-014 Port o_data, out, WORD_WIDTH: fetched word.
REQ-015 Port o_valid, out, 1: o_data valid.
REQ-016 Port o_mem_addr, out, ADDR_WIDTH: line-aligned refill address (offset bits zero).
REQ-017 Port o_mem_req_valid, out, 1: refill request.
REQ-018 Port i_mem_req_ready, in, 1: memory accepts the refill request.
REQ-019 Port i_mem_data, in, WORD_WIDTH: refill beat, one word per beat, in offset order 0 up to 2^OFFSET_BITS-1.
REQ-020 Port i_mem_data_valid, in, 1: refill beat valid.

Function
REQ-021 Storage SHALL be flop-based:
- per way and per set: valid bit, TAG_BITS tag, and 2^OFFSET_BITS data words;
- per set: log2(NUM_WAYS)-bit round-robin victim pointer, zero-width when NUM_WAYS is 1.
REQ-022 FSM states SHALL be IDLE, MISS_REQ, REFILL, RESPOND and FLUSH.
REQ-023 o_ready SHALL equal (state==IDLE) & ~i_halt & ~i_flush.
REQ-024 A request is accepted on a cycle where i_valid & o_ready; tag compare against all ways of the indexed set occurs in that cycle.
REQ-025 On a hit:
- o_data is the addressed word and o_valid=1 in the next cycle (1-cycle latency);
- the FSM stays in IDLE, so back-to-back hits reach full throughput.
REQ-026 In IDLE, o_valid SHALL drop to 0 on any cycle that follows a non-accepting cycle while i_halt is low.
REQ-027 While i_halt is high, o_data and o_valid SHALL hold their values.
REQ-028 On a miss, the FSM latches the address, selects a victim, and moves to MISS_REQ the next cycle.
- Victim is the lowest-index invalid way, else the set's round-robin pointer.
REQ-029 In MISS_REQ, o_mem_req_valid=1 and o_mem_addr={tag,set,0} SHALL be held stable until i_mem_req_ready=1, then the FSM moves to REFILL.
REQ-030 In REFILL:
- each i_mem_data_valid beat writes the victim line word at the beat counter, then increments the counter;
- beats outside REFILL SHALL be ignored.
REQ-031 On the final beat (counter = 2^OFFSET_BITS-1), in that same cycle:
- set victim valid and write its tag;
- advance the set's pointer modulo NUM_WAYS, only if the victim was not chosen as an invalid way;
- move to RESPOND.
REQ-032 In RESPOND, the latched word SHALL be driven with o_valid=1 for one cycle, then the FSM returns to IDLE.
- If i_halt is high, the FSM remains in RESPOND with o_valid=1 until i_halt drops.
REQ-033 Miss latency SHALL be: accept at cycle N, o_mem_req_valid at N+1, and o_valid exactly 1 cycle after the final beat when not halted.
REQ-034 i_flush in IDLE SHALL enter FLUSH and clear all valid bits and round-robin pointers of one set per cycle for 2^SET_BITS cycles, then return to IDLE.
- A concurrent i_valid is not accepted.
REQ-035 i_flush outside IDLE SHALL be ignored; the requester holds it until o_ready would rise.
REQ-036 i_halt SHALL NOT stall MISS_REQ, REFILL or FLUSH progress.

Reset
REQ-037 While arst is high, all of the following SHALL be zero:
- state=IDLE and beat counter=0;
- all valid bits and pointers;
- o_valid, o_mem_req_valid, o_mem_addr and o_data.
REQ-038 arst asserted mid-refill or mid-flush SHALL abort the operation immediately, with no partial line marked valid after release.
REQ-039 Tag and data storage SHALL NOT require reset.

Verification
REQ-040 Cold miss then hit, defaults:
- fetch 0x1234 -> o_mem_addr=0x1230; 16 beats of data = 0x100+offset -> o_data=0x00104 one cycle after the last beat;
- refetch 0x1237 -> o_data=0x00107 at 1-cycle latency, no memory request.
REQ-041 Replacement: fill 4 ways of set 3 with tags 0x01..0x04, then miss tag 0x05 -> way 0 evicted; tag 0x01 now misses and tag 0x02 hits.
REQ-042 Request backpressure: hold i_mem_req_ready=0 for 10 cycles -> o_mem_req_valid and o_mem_addr stable throughout and o_ready=0; gaps between beats are tolerated.
REQ-043 Flush: after REQ-040, pulse i_flush -> o_ready=0 for 16 cycles; a subsequent fetch of 0x1234 misses.
REQ-044 Halt: raise i_halt during RESPOND for 3 cycles -> o_valid/o_data held 4 cycles total; i_halt during REFILL does not stop beat capture.
REQ-045 Reset at beat 8 of a refill -> after release, the same address misses and o_mem_req_valid rises the cycle after accept.
